// File: rtl/npc_ifu_if.sv
// Fetch-unit bus bundle: execute redirect, imem request/response and decoder instruction channel.
// master = fetch unit side, slave = memory/decoder/execute side.
interface npc_ifu_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
    input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc
  );
endinterface

// File: rtl/npc_ifu.sv
// Instruction fetch unit: one outstanding imem word read, credit-limited into a small {pc, inst} FIFO.
// Instruction visible one cycle after its response; decoder stalls via inst_ready, memory via imem_req_ready.
module npc_ifu_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push_vld,
  input  logic [WIDTH-1:0]       push_dat,
  output logic                   pop_vld,
  input  logic                   pop_rdy,
  output logic [WIDTH-1:0]       pop_dat,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign pop_vld = (count != '0);
  assign pop_dat = mem[rd_ptr];
  assign do_pop  = pop_vld && pop_rdy;
  assign do_push = push_vld && ((count != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

module npc_ifu #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input logic       clk,
  input logic       rst,
  npc_ifu_if.master bus
);
  localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic {ST_REQ, ST_WAIT} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_ent_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] req_pc;
  logic        kill;
  logic        req_vld_q;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic        redirect;
  logic [31:0] redirect_pc_al;
  logic        hs;
  logic        push;
  logic        pop;
  logic        head_vld;
  fetch_ent_t  push_ent;
  fetch_ent_t  head_ent;

  assign redirect       = bus.redirect_valid;
  assign redirect_pc_al = bus.redirect_pc & ~32'h3;

  // A redirect cycle never issues: the new PC is requested from the following cycle.
  assign bus.imem_req_valid = req_vld_q && !redirect;
  assign bus.imem_req_addr  = fetch_pc;
  assign hs                 = bus.imem_req_valid && bus.imem_req_ready;

  assign push     = (state == ST_WAIT) && bus.imem_rsp_valid && !kill && !redirect;
  assign pop      = head_vld && bus.inst_ready && !redirect;
  assign push_ent = {req_pc, bus.imem_rsp_data};

  // Occupancy after this edge; drives the credit check for the next request.
  assign count_nxt = redirect ? '0 : (count + CW'(push) - CW'(pop));

  npc_ifu_fifo #(
    .WIDTH ($bits(fetch_ent_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect),
    .push_vld (push),
    .push_dat (push_ent),
    .pop_vld  (head_vld),
    .pop_rdy  (bus.inst_ready),
    .pop_dat  (head_ent),
    .count    (count)
  );

  assign bus.inst_valid = head_vld;
  assign bus.inst       = head_ent.inst;
  assign bus.inst_pc    = head_ent.pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_REQ;
      fetch_pc  <= RESET_PC;
      req_pc    <= '0;
      kill      <= 1'b0;
      req_vld_q <= 1'b0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc_al;
      // A response still owed by memory must be swallowed when it shows up.
      if (hs || ((state == ST_WAIT) && !bus.imem_rsp_valid)) begin
        state     <= ST_WAIT;
        kill      <= 1'b1;
        req_vld_q <= 1'b0;
      end else begin
        state     <= ST_REQ;
        kill      <= 1'b0;
        req_vld_q <= 1'b1;
      end
    end else begin
      case (state)
        ST_REQ: begin
          if (hs) begin
            req_pc    <= fetch_pc;
            fetch_pc  <= fetch_pc + 32'd4;
            state     <= ST_WAIT;
            req_vld_q <= 1'b0;
          end else begin
            req_vld_q <= (count_nxt < DEPTH_C);
          end
        end
        ST_WAIT: begin
          if (bus.imem_rsp_valid) begin
            kill      <= 1'b0;
            state     <= ST_REQ;
            req_vld_q <= (count_nxt < DEPTH_C);
          end
        end
        default: begin
          state     <= ST_REQ;
          req_vld_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_npc_ifu.sv
// Directed bench for npc_ifu: reset, streaming, stall, redirect corner cases, memory stalls, async reset.
module tb_npc_ifu;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  npc_ifu_if bus ();

  npc_ifu #(
    .RESET_PC   (32'h8000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          total = 0;
  int          bad   = 0;
  int          cyc;
  int          hs_cnt;
  int          lat;
  int          pend;
  logic [31:0] pend_addr;
  logic [63:0] got [$];
  int          got_cyc [$];

  function automatic logic [63:0] ent(input logic [31:0] pc);
    return {pc, pc ^ 32'hA5A5_A5A5};
  endfunction

  function automatic logic [63:0] got_at(input int k);
    return (k < got.size()) ? got[k] : 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  function automatic int cyc_at(input int k);
    return (k < got_cyc.size()) ? got_cyc[k] : -1000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes mid-cycle, cross the edge, then play the memory side.
  task automatic tick();
    logic        hs_s;
    logic [31:0] a_s;
    #1;
    hs_s = bus.imem_req_valid && bus.imem_req_ready;
    a_s  = bus.imem_req_addr;
    if (bus.inst_valid && bus.inst_ready && !bus.redirect_valid) begin
      got.push_back({bus.inst_pc, bus.inst});
      got_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    bus.redirect_valid = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    if (hs_s) begin
      hs_cnt++;
      pend      = lat;
      pend_addr = a_s;
    end
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = pend_addr ^ 32'hA5A5_A5A5;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst                = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    pend               = 0;
    tick();
    tick();
    got.delete();
    got_cyc.delete();
    hs_cnt = 0;
    cyc    = 0;
    rst    = 1'b1;
  endtask

  task automatic drain(input int n, input int bound, input string tag);
    for (int i = 0; i < bound && got.size() < n; i++) tick();
    chk(tag, got.size(), n);
  endtask

  initial begin
    rst                = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.inst_ready     = 1'b1;
    lat    = 1;
    pend   = 0;
    cyc    = 0;
    hs_cnt = 0;

    tick();
    tick();
    chk("rst_req_valid",  bus.imem_req_valid, 0);
    chk("rst_req_addr",   bus.imem_req_addr, 32'h8000_0000);
    chk("rst_inst_valid", bus.inst_valid, 0);
    chk("rst_inst",       bus.inst, 0);
    chk("rst_inst_pc",    bus.inst_pc, 0);

    // Streaming with zero-wait memory
    do_reset();
    tick();
    chk("s_first_req_valid", bus.imem_req_valid, 1);
    chk("s_first_req_addr",  bus.imem_req_addr, 32'h8000_0000);
    drain(3, 30, "s_count");
    chk("s_e0", got_at(0), ent(32'h8000_0000));
    chk("s_e1", got_at(1), ent(32'h8000_0004));
    chk("s_e2", got_at(2), ent(32'h8000_0008));
    chk("s_gap01", cyc_at(1) - cyc_at(0), 2);
    chk("s_gap12", cyc_at(2) - cyc_at(1), 2);

    // Decoder stall fills the buffer, then drains in order
    bus.inst_ready = 1'b0;
    do_reset();
    repeat (12) tick();
    chk("st_none_taken", got.size(), 0);
    chk("st_req_count",  hs_cnt, 2);
    chk("st_req_valid",  bus.imem_req_valid, 0);
    chk("st_head_valid", bus.inst_valid, 1);
    chk("st_head",       {bus.inst_pc, bus.inst}, ent(32'h8000_0000));
    bus.inst_ready = 1'b1;
    drain(3, 30, "st_count");
    chk("st_e0", got_at(0), ent(32'h8000_0000));
    chk("st_e1", got_at(1), ent(32'h8000_0004));
    chk("st_e2", got_at(2), ent(32'h8000_0008));

    // Redirect while waiting on memory, with one entry buffered
    bus.inst_ready = 1'b0;
    lat = 3;
    do_reset();
    repeat (6) tick();
    chk("rw_pre_valid", bus.inst_valid, 1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0103;
    #1;
    chk("rw_req_forced", bus.imem_req_valid, 0);
    tick();
    chk("rw_flushed", bus.inst_valid, 0);
    bus.inst_ready = 1'b1;
    tick();
    tick();
    chk("rw_killed",    bus.inst_valid, 0);
    chk("rw_req_valid", bus.imem_req_valid, 1);
    chk("rw_req_addr",  bus.imem_req_addr, 32'h8000_0100);
    drain(1, 20, "rw_count");
    chk("rw_first", got_at(0), ent(32'h8000_0100));

    // Redirect in the same cycle as the response
    lat = 1;
    do_reset();
    tick();
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_1000;
    tick();
    chk("rr_dropped",   bus.inst_valid, 0);
    chk("rr_req_valid", bus.imem_req_valid, 1);
    chk("rr_req_addr",  bus.imem_req_addr, 32'h0000_1000);
    drain(2, 20, "rr_count");
    chk("rr_e0", got_at(0), ent(32'h0000_1000));
    chk("rr_e1", got_at(1), ent(32'h0000_1004));

    // Redirect in the cycle a request would have handshaken
    do_reset();
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_2002;
    #1;
    chk("rh_req_forced", bus.imem_req_valid, 0);
    tick();
    chk("rh_no_hs",     hs_cnt, 0);
    chk("rh_req_valid", bus.imem_req_valid, 1);
    chk("rh_req_addr",  bus.imem_req_addr, 32'h0000_2000);
    drain(1, 20, "rh_count");
    chk("rh_first", got_at(0), ent(32'h0000_2000));

    // Memory refuses for 5 cycles, then answers 3 cycles late
    bus.imem_req_ready = 1'b0;
    lat = 3;
    do_reset();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("ms_hold_valid", bus.imem_req_valid, 1);
      chk("ms_hold_addr",  bus.imem_req_addr, 32'h8000_0000);
      tick();
    end
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
    chk("ms_one_req", hs_cnt, 1);
    repeat (10) tick();
    chk("ms_once", got.size(), 1);
    chk("ms_e0",   got_at(0), ent(32'h8000_0000));

    // Asynchronous reset mid-transaction
    bus.imem_req_ready = 1'b1;
    bus.inst_ready     = 1'b0;
    do_reset();
    repeat (6) tick();
    chk("ar_pre_valid", bus.inst_valid, 1);
    rst = 1'b0;
    #1;
    chk("ar_req_valid",  bus.imem_req_valid, 0);
    chk("ar_req_addr",   bus.imem_req_addr, 32'h8000_0000);
    chk("ar_inst_valid", bus.inst_valid, 0);
    chk("ar_inst",       bus.inst, 0);
    chk("ar_inst_pc",    bus.inst_pc, 0);
    pend               = 0;
    bus.imem_rsp_valid = 1'b0;
    tick();
    tick();
    got.delete();
    got_cyc.delete();
    rst            = 1'b1;
    bus.inst_ready = 1'b1;
    tick();
    chk("ar_restart_valid", bus.imem_req_valid, 1);
    chk("ar_restart_addr",  bus.imem_req_addr, 32'h8000_0000);
    drain(1, 20, "ar_count");
    chk("ar_first", got_at(0), ent(32'h8000_0000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/npc_ifu.md
Name: npc_ifu

Overview:
Instruction fetch unit directly upstream of the single-cycle npc core. It owns the fetch PC and issues word reads to instruction memory over a valid/ready request channel plus a valid-only response channel. Fetched {pc, inst} pairs are buffered in a small FIFO and presented to the decoder through a valid/ready handshake. A redirect port from the execute stage (branch/jump) flushes in-flight work and restarts fetch at a new PC.

Parameters:
RESET_PC, 32'h8000_0000, first fetch address after reset
FIFO_DEPTH, 2, instruction buffer entries (power of two, >=2)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low
redirect_valid  input  1  execute requests a fetch restart
redirect_pc  input  32  restart address; bits [1:0] are ignored and treated as 0
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  32  word-aligned fetch address
imem_rsp_valid  input  1  read data valid, no backpressure
imem_rsp_data  input  32  instruction word
inst_valid  output  1  FIFO head valid to decoder
inst_ready  input  1  decoder consumes head
inst  output  32  instruction at FIFO head
inst_pc  output  32  PC of that instruction

Behaviour:
- Reset (rst=0, async): fetch_pc=RESET_PC, FSM=REQ, FIFO empty, kill=0, imem_req_valid=0, imem_req_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0.
- FSM states:
  - REQ: imem_req_valid=1 iff (fifo_count < FIFO_DEPTH) and no redirect this cycle; imem_req_addr=fetch_pc. On handshake: fetch_pc += 4 (32-bit wrap, 0xFFFF_FFFC -> 0), go to WAIT.
  - WAIT: imem_req_valid=0. On imem_rsp_valid: if kill=0, push {pc_of_request, imem_rsp_data}; clear kill; go to REQ.
- At most one outstanding request. Credit rule: count + outstanding <= FIFO_DEPTH, so a response never finds the FIFO full. rsp_valid outside WAIT is ignored.
- Throughput: with zero-wait memory (rsp one cycle after req handshake), one instruction per 2 cycles. inst_valid rises one cycle after the accepted rsp_valid (registered FIFO, no bypass).
- FIFO pop when inst_valid & inst_ready. Push and pop in the same cycle is legal when full or empty-with-push (count unchanged, or count+1). inst and inst_pc are stable while inst_valid=1 and inst_ready=0.
- Redirect (highest priority, applied in the cycle redirect_valid=1):
  - The FIFO is flushed and inst_valid=0 next cycle; a same-cycle pop is discarded.
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - In REQ, imem_req_valid is forced 0 in the redirect cycle; the new address is requested from the next cycle.
  - In WAIT, or if a request handshake completed in the same cycle, kill=1 so the in-flight response is dropped. If the response arrives in the redirect cycle itself, it is dropped.
  - Back-to-back redirects: the last one wins.
- Reset asserted mid-transaction clears all state immediately. The memory must also be reset, because a stale response after reset release is ignored only when the FSM is in REQ.
- Invariant: inst_pc sequence between redirects is strictly +4.

Test Plan:
- Release reset, zero-wait memory returning addr^0xA5A5_A5A5, inst_ready=1 -> first req addr 0x8000_0000 in the first cycle after release; inst_pc 0x8000_0000, 0x8000_0004, 0x8000_0008 appear every 2 cycles with matching data.
- inst_ready=0 for 10 cycles -> exactly 2 entries are buffered (0x8000_0000, 0x8000_0004), no further req; resuming ready drains them in order with no loss or duplication.
- Redirect to 0x8000_0103 while in WAIT -> in-flight response is dropped, FIFO is empty next cycle, next req addr is 0x8000_0100, and the first delivered inst_pc is 0x8000_0100.
- redirect_valid in the same cycle as imem_rsp_valid, and separately in the same cycle as a req handshake -> the response is dropped in both cases; no instruction from the old path reaches the inst port.
- Memory holds imem_req_ready=0 for 5 cycles, then delays rsp by 3 cycles -> req_valid and addr are held stable, and the instruction is delivered exactly once.
- Assert rst while in WAIT with the FIFO full, then release -> all outputs return to reset values asynchronously, and fetch restarts at 0x8000_0000.
